multi_lane_compress_merger: RTL

MULTI_LANE_COMPRESS_MERGER -- requirements
Module: multi_lane_compress_merger

---
 rtl/cpr_pkg.sv | 30 +++
 rtl/cpr_merge_stage.sv | 76 +++++++
 rtl/multi_lane_compress_merger.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cpr_pkg.sv
// Shared tag encoding and tag-to-length mapping for the compressed-lane merger.
// Pure definitions, no logic or latency of its own.
// No flow control here; users apply their own pipeline enables.
package cpr_pkg;

  localparam int unsigned TAG_NONE = 0;
  localparam int unsigned TAG_BYTE = 1;
  localparam int unsigned TAG_HALF = 2;
  localparam int unsigned TAG_FULL = 3;

  localparam int unsigned LEN_BYTE = 8;
  localparam int unsigned LEN_HALF = 16;

  // Valid bit count of a lane for a given tag. Any code above TAG_FULL
  // (only reachable with wider tags) means a full, uncompressed word.
  // Clamped to the lane width so narrow lanes never claim more bits than they hold.
  function automatic int unsigned cpr_tag_len(input int unsigned tag, input int unsigned data_width);
    int unsigned len;
    case (tag)
      TAG_NONE: len = 0;
      TAG_BYTE: len = LEN_BYTE;
      TAG_HALF: len = LEN_HALF;
      TAG_FULL: len = data_width;
      default:  len = data_width;
    endcase
    if (len > data_width) len = data_width;
    return len;
  endfunction

endpackage

// File: rtl/cpr_merge_stage.sv
// One merge level: packs each adjacent (lower, upper) element pair into one element.
// Latency: 1 cycle (registered outputs).
// Advances only when i_en is high; otherwise holds every output register.
module cpr_merge_stage
  import cpr_pkg::*;
#(
  parameter int PAIRS     = 4,
  parameter int IN_WIDTH  = 32,
  parameter int TAG_WIDTH = 2,
  parameter int LEN_WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_en,
  input  logic                         i_vld,
  input  logic                         i_last,
  input  logic [2*PAIRS*IN_WIDTH-1:0]  i_dat,
  input  logic [2*PAIRS*TAG_WIDTH-1:0] i_tag,
  input  logic [2*PAIRS*LEN_WIDTH-1:0] i_len,
  output logic                         o_vld,
  output logic                         o_last,
  output logic [2*PAIRS*IN_WIDTH-1:0]  o_dat,
  output logic [2*PAIRS*TAG_WIDTH-1:0] o_tag,
  output logic [PAIRS*LEN_WIDTH-1:0]   o_len
);

  logic [2*PAIRS*IN_WIDTH-1:0] w_dat;
  logic [PAIRS*LEN_WIDTH-1:0]  w_len;

  logic                         r_vld;
  logic                         r_last;
  logic [2*PAIRS*IN_WIDTH-1:0]  r_dat;
  logic [2*PAIRS*TAG_WIDTH-1:0] r_tag;
  logic [PAIRS*LEN_WIDTH-1:0]   r_len;

  // Upper element slides in directly above the valid bits of the lower one;
  // both inputs already have zeros above their lengths, so OR is a clean pack.
  for (genvar p = 0; p < PAIRS; p++) begin : g_pair
    logic [2*IN_WIDTH-1:0] w_lo;
    logic [2*IN_WIDTH-1:0] w_hi;
    logic [LEN_WIDTH-1:0]  w_len_lo;
    logic [LEN_WIDTH-1:0]  w_len_hi;

    assign w_lo     = {{IN_WIDTH{1'b0}}, i_dat[2*p*IN_WIDTH +: IN_WIDTH]};
    assign w_hi     = {{IN_WIDTH{1'b0}}, i_dat[(2*p+1)*IN_WIDTH +: IN_WIDTH]};
    assign w_len_lo = i_len[2*p*LEN_WIDTH +: LEN_WIDTH];
    assign w_len_hi = i_len[(2*p+1)*LEN_WIDTH +: LEN_WIDTH];

    assign w_dat[2*p*IN_WIDTH +: 2*IN_WIDTH] = w_lo | (w_hi << w_len_lo);
    assign w_len[p*LEN_WIDTH +: LEN_WIDTH]   = w_len_lo + w_len_hi;
  end

  // Stage register; tags are already laid out {upper, lower} so they pass straight through.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_last <= 1'b0;
      r_dat  <= '0;
      r_tag  <= '0;
      r_len  <= '0;
    end else if (i_en) begin
      r_vld  <= i_vld;
      r_last <= i_last;
      r_dat  <= w_dat;
      r_tag  <= i_tag;
      r_len  <= w_len;
    end
  end

  assign o_vld  = r_vld;
  assign o_last = r_last;
  assign o_dat  = r_dat;
  assign o_tag  = r_tag;
  assign o_len  = r_len;

endmodule

// File: rtl/multi_lane_compress_merger.sv
// Packs NUM_LANES variable-length compressed lane words into one LSB-first bit stream.
// Latency: log2(NUM_LANES)+1 cycles from accepted beat to outValid; one beat per cycle.
// Single global enable: whole pipeline freezes while outValid && !outReady (inReady low). Optional CPR_STATS_EN adds handshake counters.
module multi_lane_compress_merger
  import cpr_pkg::*;
#(
  parameter int NUM_LANES  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2,
  localparam int LEN_WIDTH = $clog2(NUM_LANES*DATA_WIDTH+1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic                            inLast,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] cprDataIn,
  input  logic [NUM_LANES*TAG_WIDTH-1:0]  tagIn,
  output logic                            outValid,
  input  logic                            outReady,
  output logic                            outLast,
  output logic [NUM_LANES*DATA_WIDTH-1:0] dataOut,
  output logic [NUM_LANES*TAG_WIDTH-1:0]  tagOut,
  output logic [LEN_WIDTH-1:0]            lenOut
`ifdef CPR_STATS_EN
  ,
  output logic [31:0]                     statBeats,
  output logic [47:0]                     statBits
`endif
);

  localparam int LAT    = $clog2(NUM_LANES) + 1;
  localparam int LEVELS = LAT - 1;

  logic w_en;

  logic [NUM_LANES*DATA_WIDTH-1:0] w_lane_dat;
  logic [NUM_LANES*LEN_WIDTH-1:0]  w_lane_len;

  logic                            r_s0_vld;
  logic                            r_s0_last;
  logic [NUM_LANES*DATA_WIDTH-1:0] r_s0_dat;
  logic [NUM_LANES*TAG_WIDTH-1:0]  r_s0_tag;
  logic [NUM_LANES*LEN_WIDTH-1:0]  r_s0_len;

  // Chain between levels; index 0 is the input stage, LEVELS is the output register.
  logic [LEVELS:0]                 w_vld_chain;
  logic [LEVELS:0]                 w_last_chain;
  logic [NUM_LANES*DATA_WIDTH-1:0] w_dat_chain [0:LEVELS];
  logic [NUM_LANES*TAG_WIDTH-1:0]  w_tag_chain [0:LEVELS];
  logic [NUM_LANES*LEN_WIDTH-1:0]  w_len_chain [0:LEVELS];

  assign w_en    = !outValid || outReady;
  assign inReady = w_en;

  // Per-lane length decode and masking of garbage above the valid bits.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LEN_WIDTH-1:0]  w_len;
    logic [DATA_WIDTH-1:0] w_mask;

    assign w_len  = LEN_WIDTH'(cpr_tag_len(32'(tagIn[l*TAG_WIDTH +: TAG_WIDTH]), 32'(DATA_WIDTH)));
    assign w_mask = (w_len >= LEN_WIDTH'(DATA_WIDTH)) ? {DATA_WIDTH{1'b1}}
                                                      : ~({DATA_WIDTH{1'b1}} << w_len);

    assign w_lane_dat[l*DATA_WIDTH +: DATA_WIDTH] = cprDataIn[l*DATA_WIDTH +: DATA_WIDTH] & w_mask;
    assign w_lane_len[l*LEN_WIDTH +: LEN_WIDTH]   = w_len;
  end

  // Input stage register: masked lanes, lengths, tags and beat sideband.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0_vld  <= 1'b0;
      r_s0_last <= 1'b0;
      r_s0_dat  <= '0;
      r_s0_tag  <= '0;
      r_s0_len  <= '0;
    end else if (w_en) begin
      r_s0_vld  <= inValid;
      r_s0_last <= inValid && inLast;
      r_s0_dat  <= w_lane_dat;
      r_s0_tag  <= tagIn;
      r_s0_len  <= w_lane_len;
    end
  end

  assign w_vld_chain[0]  = r_s0_vld;
  assign w_last_chain[0] = r_s0_last;
  assign w_dat_chain[0]  = r_s0_dat;
  assign w_tag_chain[0]  = r_s0_tag;
  assign w_len_chain[0]  = r_s0_len;

  // Binary merge tree: each level halves the element count and doubles element width.
  for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
    localparam int PAIRS = NUM_LANES >> (g + 1);
    localparam int IN_W  = DATA_WIDTH << g;
    localparam int TAG_W = TAG_WIDTH << g;

    cpr_merge_stage #(
      .PAIRS     (PAIRS),
      .IN_WIDTH  (IN_W),
      .TAG_WIDTH (TAG_W),
      .LEN_WIDTH (LEN_WIDTH)
    ) u_merge (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_en),
      .i_vld  (w_vld_chain[g]),
      .i_last (w_last_chain[g]),
      .i_dat  (w_dat_chain[g]),
      .i_tag  (w_tag_chain[g]),
      .i_len  (w_len_chain[g][2*PAIRS*LEN_WIDTH-1:0]),
      .o_vld  (w_vld_chain[g+1]),
      .o_last (w_last_chain[g+1]),
      .o_dat  (w_dat_chain[g+1]),
      .o_tag  (w_tag_chain[g+1]),
      .o_len  (w_len_chain[g+1][PAIRS*LEN_WIDTH-1:0])
    );

    assign w_len_chain[g+1][NUM_LANES*LEN_WIDTH-1:PAIRS*LEN_WIDTH] = '0;
  end

  assign outValid = w_vld_chain[LEVELS];
  assign outLast  = w_last_chain[LEVELS];
  assign dataOut  = w_dat_chain[LEVELS];
  assign tagOut   = w_tag_chain[LEVELS];
  assign lenOut   = w_len_chain[LEVELS][LEN_WIDTH-1:0];

`ifdef CPR_STATS_EN
  // Count output handshakes and the bits they carried; both wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      statBeats <= '0;
      statBits  <= '0;
    end else if (outValid && outReady) begin
      statBeats <= statBeats + 32'd1;
      statBits  <= statBits + 48'(lenOut);
    end
  end
`endif

endmodule
